// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_ctrl
// Purpose  : Responder for the mem_cmd/mem_en/mem_valid request interface.
//            Executes one WREN, WRITE, READ or RDSR command at a time on a
//            25xx-style SPI EEPROM (SPI mode 0) and returns a one-cycle
//            mem_valid. WRITE is followed by RDSR polling until WIP clears
//            or POLL_MAX polls have been issued.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            mem_cmd[1:0], mem_en     - command and request level
//            mem_addr[5:0], mem_data  - cell address and write data
//            mem_valid, mem_rdata     - completion pulse and read/status data
//            spi_cs_n, spi_sclk,
//            spi_mosi, spi_miso       - SPI EEPROM pins
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_ctrl #(
    parameter int CLK_DIV  = 4,   // clk cycles per SCLK half-period (>=2)
    parameter int CS_GAP   = 4,   // min clk cycles cs_n high between frames
    parameter int POLL_MAX = 0    // max RDSR polls after WRITE, 0 = unlimited
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mem_cmd,
    input  logic       mem_en,
    output logic       mem_valid,
    input  logic [5:0] mem_addr,
    input  logic [1:0] mem_data,
    output logic [1:0] mem_rdata,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_WREN  = 2'b10;
    localparam logic [1:0] CMD_RDSR  = 2'b11;

    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int HOLD_W = $clog2(CLK_DIV + CS_GAP) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_CS_LAST = HOLD_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(CLK_DIV + CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_POLL  = 3'd4,
        S_DONE  = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    state_t             state_q,    state_d;
    logic [1:0]         cmd_q,      cmd_d;
    logic [23:0]        tx_q,       tx_d;
    logic [1:0]         rx_q,       rx_d;      // last two bits received
    logic [4:0]         nbits_q,    nbits_d;
    logic [4:0]         bit_q,      bit_d;
    logic [DIV_W-1:0]   div_q,      div_d;
    logic [HOLD_W-1:0]  hold_q,     hold_d;
    logic               polling_q,  polling_d;
    logic [15:0]        poll_cnt_q, poll_cnt_d;
    logic               sclk_q,     sclk_d;
    logic               cs_n_q,     cs_n_d;
    logic [1:0]         rdata_q,    rdata_d;

    logic               poll_limit;

    assign poll_limit = (POLL_MAX != 0) && (poll_cnt_q >= 16'(POLL_MAX));

    assign mem_valid = (state_q == S_DONE);
    assign mem_rdata = rdata_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sclk  = sclk_q;
    // Shift register is zero outside a frame, so MOSI idles low.
    assign spi_mosi  = tx_q[23];

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        nbits_d    = nbits_q;
        bit_d      = bit_q;
        div_d      = div_q;
        hold_d     = hold_q;
        polling_d  = polling_q;
        poll_cnt_d = poll_cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    cmd_d      = mem_cmd;
                    polling_d  = 1'b0;
                    poll_cnt_d = 16'd0;
                    bit_d      = 5'd0;
                    div_d      = '0;
                    cs_n_d     = 1'b0;
                    state_d    = S_SETUP;
                    case (mem_cmd)
                        CMD_WREN: begin
                            tx_d    = {8'h06, 16'h0000};
                            nbits_d = 5'd8;
                        end
                        CMD_WRITE: begin
                            tx_d    = {8'h02, 2'b00, mem_addr, 6'b000000, mem_data};
                            nbits_d = 5'd24;
                        end
                        CMD_READ: begin
                            tx_d    = {8'h03, 2'b00, mem_addr, 8'h00};
                            nbits_d = 5'd24;
                        end
                        default: begin
                            tx_d    = {8'h05, 16'h0000};
                            nbits_d = 5'd16;
                        end
                    endcase
                end
            end

            // cs_n already low, first MOSI bit presented; wait one half-period.
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            // Rising edge samples MISO; falling edge advances MOSI.
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[0], spi_miso};
                    end else begin
                        tx_d = {tx_q[22:0], 1'b0};
                        if (bit_q == nbits_q - 5'd1) begin
                            hold_d  = '0;
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            // cs_n low for CLK_DIV cycles, then high for CS_GAP cycles.
            S_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_CS_LAST) begin
                    cs_n_d = 1'b1;
                end
                if (hold_q == HOLD_LAST) begin
                    // rx_q[0] holds WIP when the frame just ended was a poll.
                    if ((cmd_q == CMD_WRITE) &&
                        (!polling_q || (rx_q[0] && !poll_limit))) begin
                        state_d = S_POLL;
                    end else begin
                        state_d = S_DONE;
                        if ((cmd_q == CMD_READ) || (cmd_q == CMD_RDSR)) begin
                            rdata_d = rx_q;
                        end
                    end
                end
            end

            S_POLL: begin
                tx_d      = {8'h05, 16'h0000};
                nbits_d   = 5'd16;
                polling_d = 1'b1;
                if (poll_cnt_q != 16'hFFFF) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                end
                bit_d   = 5'd0;
                div_d   = '0;
                cs_n_d  = 1'b0;
                state_d = S_SETUP;
            end

            // A requester that already released mem_en needs no WAIT.
            S_DONE: begin
                state_d = mem_en ? S_WAIT : S_IDLE;
            end

            S_WAIT: begin
                if (!mem_en) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= 2'b00;
            tx_q       <= 24'h000000;
            rx_q       <= 2'b00;
            nbits_q    <= 5'd0;
            bit_q      <= 5'd0;
            div_q      <= '0;
            hold_q     <= '0;
            polling_q  <= 1'b0;
            poll_cnt_q <= 16'd0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rdata_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            nbits_q    <= nbits_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            hold_q     <= hold_d;
            polling_q  <= polling_d;
            poll_cnt_q <= poll_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_ctrl
// Purpose  : Directed self-checking bench for spi_mem_ctrl with a behavioural
//            25xx EEPROM model; a second instance checks POLL_MAX=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_ctrl;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_WREN  = 2'b10;
    localparam logic [1:0] CMD_RDSR  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mem_cmd;
    logic       mem_en;
    logic       mem_valid;
    logic [5:0] mem_addr;
    logic [1:0] mem_data;
    logic [1:0] mem_rdata;
    logic       spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso = 1'b0;

    logic [1:0] mem_cmd2;
    logic       mem_en2;
    logic       mem_valid2;
    logic [5:0] mem_addr2;
    logic [1:0] mem_data2;
    logic [1:0] mem_rdata2;
    logic       spi_cs_n2, spi_sclk2, spi_mosi2;
    logic       spi_miso2 = 1'b1;   // WIP stuck at 1

    always #5 clk = ~clk;

    spi_mem_ctrl #(.CLK_DIV(4), .CS_GAP(4), .POLL_MAX(0)) u_dut (
        .clk(clk), .rst(rst), .mem_cmd(mem_cmd), .mem_en(mem_en),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_rdata(mem_rdata), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_mem_ctrl #(.CLK_DIV(4), .CS_GAP(4), .POLL_MAX(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_cmd(mem_cmd2), .mem_en(mem_en2),
        .mem_valid(mem_valid2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .mem_rdata(mem_rdata2), .spi_cs_n(spi_cs_n2), .spi_sclk(spi_sclk2),
        .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- EEPROM model (instance 1) ----------------
    logic [7:0] byteq[$];
    int         lenq[$];
    int         frames    = 0;
    int         idle_cs   = 0;   // frames started while mem_en low
    int         vcnt      = 0;
    int         bitn      = 0;
    logic [7:0] rxb       = 8'h00;
    logic [7:0] op        = 8'h00;
    logic [7:0] osh       = 8'h00;
    logic [7:0] nxt       = 8'h00;
    bit         ld        = 1'b0;
    int         wip_left  = 0;
    bit         wel       = 1'b0;
    logic [7:0] read_val  = 8'hA6;

    always @(negedge spi_cs_n) begin
        bitn = 0; osh = 8'h00; ld = 1'b0; spi_miso = 1'b0; op = 8'h00;
        if (mem_en !== 1'b1) idle_cs++;
    end

    always @(posedge spi_sclk) begin
        if (spi_cs_n === 1'b0) begin
            rxb = {rxb[6:0], spi_mosi};
            bitn++;
            if (bitn % 8 == 0) begin
                byteq.push_back(rxb);
                if (bitn == 8) op = rxb;
                if (bitn == 8 && rxb == 8'h05) begin
                    nxt = {6'b000000, wel, (wip_left > 0)};
                    ld  = 1'b1;
                end
                if (bitn == 16 && op == 8'h03) begin
                    nxt = read_val;
                    ld  = 1'b1;
                end
            end
        end
    end

    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0) begin
            if (ld) begin osh = nxt; ld = 1'b0; end
            else osh = {osh[6:0], 1'b0};
            spi_miso = osh[7];
        end
    end

    always @(posedge spi_cs_n) begin
        lenq.push_back(bitn);
        if (op == 8'h05 && wip_left > 0) wip_left--;
        frames++;
    end

    always @(negedge clk) if (mem_valid === 1'b1) vcnt++;

    // ---------------- instance 2 monitors ----------------
    int frames2 = 0;
    int vcnt2   = 0;
    always @(negedge spi_cs_n2) frames2++;
    always @(negedge clk) if (mem_valid2 === 1'b1) vcnt2++;

    task automatic clear_log();
        byteq.delete(); lenq.delete(); frames = 0;
    endtask

    // Issue one request, wait (bounded) for mem_valid, then release mem_en.
    task automatic req(input string tag, input logic [1:0] c, input logic [5:0] a,
                       input logic [1:0] d, input int hold_extra,
                       output logic [1:0] rd, output int fr_at_valid);
        bit got;
        int n;
        got = 1'b0; n = 0; rd = 2'bxx; fr_at_valid = -1;
        @(negedge clk);
        mem_cmd = c; mem_addr = a; mem_data = d; mem_en = 1'b1;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (mem_valid === 1'b1) begin
                got = 1'b1; rd = mem_rdata; fr_at_valid = frames;
            end
        end
        chk({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
        repeat (hold_extra) @(negedge clk);
        mem_cmd = ~c; mem_addr = ~a; mem_data = ~d;   // must be ignored
        mem_en = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] exp_wr [11] = '{8'h02, 8'h3F, 8'h02, 8'h05, 8'h00, 8'h05, 8'h00,
                                8'h05, 8'h00, 8'h05, 8'h00};

    initial begin
        logic [1:0] rd;
        int         fr;
        int         v0;
        int         bad;
        int         n;

        rst = 1'b1; mem_en = 1'b0; mem_cmd = 2'b00; mem_addr = 6'h00; mem_data = 2'b00;
        mem_en2 = 1'b0; mem_cmd2 = 2'b00; mem_addr2 = 6'h00; mem_data2 = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_rdata", {30'd0, mem_rdata}, 32'd0);
        chk("rst_cs_n",  {31'd0, spi_cs_n},  32'd1);
        chk("rst_sclk",  {31'd0, spi_sclk},  32'd0);
        chk("rst_mosi",  {31'd0, spi_mosi},  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_log(); vcnt = 0;

        // WREN, mem_en held long after completion: only one pulse
        req("wren", CMD_WREN, 6'h00, 2'b00, 60, rd, fr);
        chk("wren_frames",  frames, 1);
        chk("wren_byte",    {24'd0, byteq[0]}, 32'h06);
        chk("wren_pulses",  lenq[0], 8);
        chk("wren_vcnt",    vcnt, 1);
        req("wren2", CMD_WREN, 6'h00, 2'b00, 0, rd, fr);
        chk("wren2_vcnt",   vcnt, 2);

        // WRITE with WIP=1 for three polls
        clear_log(); vcnt = 0; wip_left = 3;
        req("write", CMD_WRITE, 6'h3F, 2'b10, 0, rd, fr);
        chk("write_frames_at_valid", fr, 5);
        chk("write_nbytes", byteq.size(), 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("write_byte%0d", i), {24'd0, byteq[i]}, {24'd0, exp_wr[i]});
        chk("write_vcnt", vcnt, 1);

        // READ returns low bits of the third byte
        clear_log(); read_val = 8'hA6;
        req("read", CMD_READ, 6'h05, 2'b00, 0, rd, fr);
        chk("read_rdata", {30'd0, rd}, 32'h2);
        chk("read_b0", {24'd0, byteq[0]}, 32'h03);
        chk("read_b1", {24'd0, byteq[1]}, 32'h05);
        chk("read_b2", {24'd0, byteq[2]}, 32'h00);

        // WREN leaves rdata alone
        req("wren3", CMD_WREN, 6'h00, 2'b00, 0, rd, fr);
        chk("wren_keeps_rdata", {30'd0, mem_rdata}, 32'h2);

        // RDSR: status = {WEL=1, WIP=1}
        clear_log(); wel = 1'b1; wip_left = 1;
        req("rdsr", CMD_RDSR, 6'h00, 2'b00, 0, rd, fr);
        chk("rdsr_rdata", {30'd0, rd}, 32'h3);
        chk("rdsr_frame_bits", lenq[0], 16);
        wel = 1'b0;

        // WRITE leaves rdata alone
        req("write2", CMD_WRITE, 6'h01, 2'b01, 0, rd, fr);
        chk("write_keeps_rdata", {30'd0, mem_rdata}, 32'h3);

        // Back-to-back: WREN then 64 WRITEs
        clear_log(); vcnt = 0; idle_cs = 0; wip_left = 0;
        req("b2b_wren", CMD_WREN, 6'h00, 2'b00, 0, rd, fr);
        for (int i = 0; i < 64; i++)
            req("b2b_write", CMD_WRITE, 6'(i), 2'(i), 0, rd, fr);
        chk("b2b_vcnt", vcnt, 65);
        chk("b2b_idle_frames", idle_cs, 0);
        chk("b2b_nbytes", byteq.size(), 321);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (byteq[1 + 5*i] !== 8'h02 || byteq[2 + 5*i] !== 8'(i) ||
                byteq[3 + 5*i] !== 8'(i % 4)) bad++;
        end
        chk("b2b_addr_order", bad, 0);

        // Reset in the middle of a READ shift
        clear_log(); vcnt = 0;
        @(negedge clk);
        mem_cmd = CMD_READ; mem_addr = 6'h05; mem_en = 1'b1;
        n = 0;
        while (spi_cs_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("abort_frame_started", {31'd0, spi_cs_n}, 32'd0);
        repeat (40) @(negedge clk);
        rst = 1'b1; mem_en = 1'b0;
        @(negedge clk);
        chk("abort_cs_n",  {31'd0, spi_cs_n},  32'd1);
        chk("abort_sclk",  {31'd0, spi_sclk},  32'd0);
        chk("abort_valid", {31'd0, mem_valid}, 32'd0);
        chk("abort_rdata", {30'd0, mem_rdata}, 32'd0);
        rst = 1'b0;
        v0 = vcnt;
        repeat (30) @(negedge clk);
        chk("abort_no_valid", vcnt, v0);
        clear_log();
        req("read_after", CMD_READ, 6'h05, 2'b00, 0, rd, fr);
        chk("read_after_rdata", {30'd0, rd}, 32'h2);
        chk("read_after_b1", {24'd0, byteq[1]}, 32'h05);

        // POLL_MAX=2 with WIP stuck at 1
        frames2 = 0; vcnt2 = 0;
        @(negedge clk);
        mem_cmd2 = CMD_WRITE; mem_addr2 = 6'h2A; mem_data2 = 2'b01; mem_en2 = 1'b1;
        n = 0;
        while (mem_valid2 !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk("pmax_valid_seen", {31'd0, mem_valid2}, 32'd1);
        chk("pmax_frames", frames2, 3);
        @(negedge clk);
        mem_en2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pmax_vcnt", vcnt2, 1);
        mem_cmd2 = CMD_WREN; mem_en2 = 1'b1;
        n = 0;
        while (mem_valid2 !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk("pmax_idle_again", {31'd0, mem_valid2}, 32'd1);
        chk("pmax_frames2", frames2, 4);
        @(negedge clk);
        mem_en2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
